// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin arbiter that shares one 32x32 sprite ROM among NUM_REQ pixel
//   requesters. The ROM has a one-cycle registered read. At most one
//   requester is granted per cycle, and the granted row/col is forwarded to
//   the ROM. The colour word comes back one cycle later, together with a
//   one-hot valid strobe. A requester may set lock together with req to hold
//   the ROM for a back-to-back burst.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_i      asynchronous, active-high reset
//   req_i        per-requester read request (held with address until granted)
//   lock_i       per-requester burst lock, only meaningful with req_i
//   req_row_i    packed rows, requester i at [5i+4:5i]
//   req_col_i    packed cols, same packing
//   gnt_o        one-hot combinational grant
//   rom_row_o    row to ROM (0 when idle)
//   rom_col_o    col to ROM (0 when idle)
//   rom_color_i  ROM colour, valid the cycle after its address
//   rd_valid_o   registered one-hot owner of rd_data_o this cycle
//   rd_data_o    colour word, passed straight through from rom_color_i

module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     lock_i,
  input  logic [5*NUM_REQ-1:0]   req_row_i,
  input  logic [5*NUM_REQ-1:0]   req_col_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [4:0]             rom_row_o,
  output logic [4:0]             rom_col_o,
  input  logic [11:0]            rom_color_i,
  output logic [NUM_REQ-1:0]     rd_valid_o,
  output logic [11:0]            rd_data_o
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        idx_s;
  logic                 found_s;

  // Next index modulo NUM_REQ.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      return '0;
    end else begin
      return idx + PW'(1);
    end
  endfunction

  // Grant selection and next-state for pointer / lock.
  always_comb begin
    gnt_d   = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    found_s = 1'b0;
    idx_s   = ptr_q;
    if (reset_i) begin
      // Forced idle so nothing reaches the ROM while reset is high.
      gnt_d = '0;
    end else if (state_q == ST_LOCK) begin
      if (req_i[owner_q] && lock_i[owner_q]) begin
        gnt_d[owner_q] = 1'b1;
      end else begin
        // Release cycle: only the owner may still get a final unlocked grant.
        state_d = ST_ARB;
        ptr_d   = wrap_inc(owner_q);
        if (req_i[owner_q]) begin
          gnt_d[owner_q] = 1'b1;
        end else begin
          gnt_d = '0;
        end
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found_s && req_i[idx_s]) begin
          found_s      = 1'b1;
          gnt_d[idx_s] = 1'b1;
          if (lock_i[idx_s]) begin
            // Locked grant keeps ptr so the rotation resumes after the owner.
            state_d = ST_LOCK;
            owner_d = idx_s;
          end else begin
            ptr_d = wrap_inc(idx_s);
          end
        end else begin
          found_s = found_s;
        end
        idx_s = wrap_inc(idx_s);
      end
    end
  end

  // Address mux: AND-OR of the one-hot grant, so an idle cycle drives 0.
  always_comb begin
    rom_row_o = 5'd0;
    rom_col_o = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rom_row_o = rom_row_o | ({5{gnt_d[i]}} & req_row_i[5*i +: 5]);
      rom_col_o = rom_col_o | ({5{gnt_d[i]}} & req_col_i[5*i +: 5]);
    end
  end

  // Arbiter state and one-cycle delayed grant for the read-return strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o      = gnt_d;
  assign rd_valid_o = gnt_q;
  assign rd_data_o  = rom_color_i;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (NUM_REQ = 3) with a small ROM model.
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  lock;
  logic [4:0]  r0, c0, r1, c1, r2, c2;
  logic [14:0] req_row;
  logic [14:0] req_col;
  logic [2:0]  gnt;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_color;
  logic [2:0]  rd_valid;
  logic [11:0] rd_data;

  int vectors;
  int miscompares;

  assign req_row = {r2, r1, r0};
  assign req_col = {c2, c1, c0};

  sprite_rom_arbiter #(.NUM_REQ(3)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .lock_i      (lock),
    .req_row_i   (req_row),
    .req_col_i   (req_col),
    .gnt_o       (gnt),
    .rom_row_o   (rom_row),
    .rom_col_o   (rom_col),
    .rom_color_i (rom_color),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [4:0] row, input logic [4:0] col);
    if (row == 5'd0 && col == 5'd0) return 12'h6CC;
    else if (row == 5'd0 && col == 5'd1) return 12'h877;
    else return {2'b00, row, col};
  endfunction

  // Sprite ROM with one-cycle registered read.
  always @(posedge clk) rom_color <= rom_fn(rom_row, rom_col);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] eg, input logic [4:0] er,
                     input logic [4:0] ec, input logic [2:0] ev);
    check({tag, "_gnt"}, {13'd0, gnt}, {13'd0, eg});
    check({tag, "_row"}, {11'd0, rom_row}, {11'd0, er});
    check({tag, "_col"}, {11'd0, rom_col}, {11'd0, ec});
    check({tag, "_rdv"}, {13'd0, rd_valid}, {13'd0, ev});
  endtask

  task automatic step(input logic [2:0] rq, input logic [2:0] lk);
    @(negedge clk);
    req  = rq;
    lock = lk;
    #1;
  endtask

  logic [2:0] fair_gnt [6];
  logic [4:0] fair_row [6];
  logic [4:0] fair_col [6];
  logic [2:0] fair_rdv [6];

  initial begin
    vectors = 0;
    miscompares = 0;
    fair_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    fair_row = '{5'd3, 5'd0, 5'd7, 5'd3, 5'd0, 5'd7};
    fair_col = '{5'd4, 5'd1, 5'd9, 5'd4, 5'd1, 5'd9};
    fair_rdv = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    reset = 1'b1;
    req   = 3'b111;
    lock  = 3'b000;
    r0 = 5'd3; c0 = 5'd4;
    r1 = 5'd0; c1 = 5'd1;
    r2 = 5'd7; c2 = 5'd9;

    // Reset held with every request high.
    step(3'b111, 3'b000);
    cyc("rst_a", 3'b000, 5'd0, 5'd0, 3'b000);
    step(3'b111, 3'b000);
    cyc("rst_b", 3'b000, 5'd0, 5'd0, 3'b000);

    // Fairness: release reset, all requesting for six cycles.
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(3'b111, 3'b000);
      cyc($sformatf("fair%0d", k), fair_gnt[k], fair_row[k], fair_col[k], fair_rdv[k]);
      if (k == 2) check("fair_data", {4'd0, rd_data}, 16'h0877);
    end

    // Single reads: (0,1) by requester 1, then (0,0) by requester 0.
    r0 = 5'd0; c0 = 5'd0;
    step(3'b010, 3'b000);
    cyc("rd1", 3'b010, 5'd0, 5'd1, 3'b100);
    step(3'b001, 3'b000);
    cyc("rd0", 3'b001, 5'd0, 5'd0, 3'b010);
    check("rd1_data", {4'd0, rd_data}, 16'h0877);

    // Idle gap of three cycles.
    step(3'b000, 3'b000);
    cyc("idle0", 3'b000, 5'd0, 5'd0, 3'b001);
    check("rd0_data", {4'd0, rd_data}, 16'h06CC);
    step(3'b000, 3'b000);
    cyc("idle1", 3'b000, 5'd0, 5'd0, 3'b000);
    step(3'b000, 3'b000);
    cyc("idle2", 3'b000, 5'd0, 5'd0, 3'b000);
    // ptr preserved at 1 across the gap.
    step(3'b111, 3'b000);
    cyc("after_idle", 3'b010, 5'd0, 5'd1, 3'b000);

    // Lock burst by requester 2 for four cycles.
    step(3'b111, 3'b100);
    cyc("lock1", 3'b100, 5'd7, 5'd9, 3'b010);
    for (int k = 2; k <= 4; k++) begin
      step(3'b111, 3'b100);
      cyc($sformatf("lock%0d", k), 3'b100, 5'd7, 5'd9, 3'b100);
    end
    step(3'b011, 3'b000);
    cyc("release", 3'b000, 5'd0, 5'd0, 3'b100);
    step(3'b011, 3'b000);
    cyc("post_rel", 3'b001, 5'd0, 5'd0, 3'b000);

    // Release with req still high but lock dropped: final grant to owner.
    step(3'b010, 3'b010);
    cyc("fin_lock", 3'b010, 5'd0, 5'd1, 3'b001);
    step(3'b010, 3'b000);
    cyc("fin_grant", 3'b010, 5'd0, 5'd1, 3'b010);
    step(3'b111, 3'b000);
    cyc("fin_next", 3'b100, 5'd7, 5'd9, 3'b010);

    // A lock on a losing requester has no effect.
    step(3'b011, 3'b010);
    cyc("lose_a", 3'b001, 5'd0, 5'd0, 3'b100);
    step(3'b001, 3'b000);
    cyc("lose_b", 3'b001, 5'd0, 5'd0, 3'b001);

    // Reset mid-burst with ptr=1: requester 0 locked.
    step(3'b001, 3'b001);
    cyc("mb_a1", 3'b001, 5'd0, 5'd0, 3'b001);
    step(3'b001, 3'b001);
    cyc("mb_a2", 3'b001, 5'd0, 5'd0, 3'b001);
    reset = 1'b1;
    #1;
    cyc("mb_a_rst", 3'b000, 5'd0, 5'd0, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b011;
    lock  = 3'b000;
    #1;
    cyc("mb_a_after", 3'b001, 5'd0, 5'd0, 3'b000);

    // Reset mid-burst with requester 1 locked: lock must not survive.
    step(3'b010, 3'b010);
    cyc("mb_b1", 3'b010, 5'd0, 5'd1, 3'b001);
    step(3'b010, 3'b010);
    cyc("mb_b2", 3'b010, 5'd0, 5'd1, 3'b010);
    reset = 1'b1;
    #1;
    cyc("mb_b_rst", 3'b000, 5'd0, 5'd0, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b001;
    lock  = 3'b000;
    #1;
    cyc("mb_b_after", 3'b001, 5'd0, 5'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
